mod_exp_engine: RTL and testbench

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

---
 rtl/mod_exp_engine.sv | 200 ++++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: result = base^exponent mod modulus.
// Right-to-left square-and-multiply. Each modular multiply is an interleaved
// shift-add over 2*WIDTH cycles. The base is reduced by restoring
// shift-subtract before the loop starts.
// Optional build macro: MODEXP_EARLY_EXIT_EN. When defined, the loop stops as
// soon as the exponent runs out. Otherwise the engine runs constant-time:
// every exponent bit costs one MULT and one SQUARE, and a MULT on a 0 bit
// lands in a scratch register.
module mod_exp_engine #(
  parameter int unsigned WIDTH = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] base,
  input  logic [2*WIDTH-1:0] exponent,
  input  logic [2*WIDTH-1:0] modulus,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               finish
);

  localparam int unsigned N  = 2 * WIDTH;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {StIdle, StReduce, StMult, StSquare, StDone} state_t;

  state_t         state_q;
  logic [N-1:0]   base_q;
  logic [N-1:0]   exp_q;
  logic [N-1:0]   n_q;
  logic [N-1:0]   rem_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   acc_q;
  // Element 1 is the running result r; element 0 is the scratch destination.
  logic [N-1:0]   dst_q [2];
  logic [CW-1:0]  cnt_q;
`ifndef MODEXP_EARLY_EXIT_EN
  logic [CW-1:0]  bits_q;
`endif

  logic [N:0]     nx;
  logic [N:0]     rem_sh;
  logic [N:0]     rem_red;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   mul_src;
  logic [IW-1:0]  idx;
  logic [N:0]     dbl;
  logic [N:0]     dbl_red;
  logic [N:0]     add;
  logic [N:0]     add_red;
  logic [N-1:0]   acc_next;

  // Datapath: one reduction step and one multiply step, each with a single
  // conditional subtraction per stage on (N+1)-bit values.
  always_comb begin
    nx       = {1'b0, n_q};
    rem_sh   = {rem_q, base_q[N-1]};
    rem_red  = (rem_sh >= nx) ? (rem_sh - nx) : rem_sh;
    rem_next = rem_red[N-1:0];
    // The multiplier is r in MULT and b in SQUARE; the multiplicand is always b.
    mul_src  = (state_q == StSquare) ? b_q : dst_q[1];
    idx      = IW'(N - 1) - cnt_q[IW-1:0];
    dbl      = {acc_q, 1'b0};
    dbl_red  = (dbl >= nx) ? (dbl - nx) : dbl;
    add      = {1'b0, dbl_red[N-1:0]} + (mul_src[idx] ? {1'b0, b_q} : '0);
    add_red  = (add >= nx) ? (add - nx) : add;
    acc_next = add_red[N-1:0];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      dst_q[0] <= '0;
      dst_q[1] <= '0;
      cnt_q    <= '0;
`ifndef MODEXP_EARLY_EXIT_EN
      bits_q   <= '0;
`endif
      result   <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            n_q    <= modulus;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (modulus < N'(2)) begin
              // Everything is congruent to 0 mod 0/1: answer straight away.
              result  <= '0;
              finish  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StDone;
            end else begin
              finish  <= 1'b0;
              busy    <= 1'b1;
              state_q <= StReduce;
            end
          end
        end

        StReduce: begin
          if (cnt_q == '0) begin
            // Setup cycle: r = 1 (n >= 2 here, so 1 mod n is 1).
            dst_q[1] <= N'(1);
            acc_q    <= '0;
            cnt_q    <= CW'(1);
          end else begin
            rem_q  <= rem_next;
            base_q <= base_q << 1;
            if (cnt_q == CW'(N)) begin
              b_q   <= rem_next;
              cnt_q <= '0;
`ifdef MODEXP_EARLY_EXIT_EN
              if (exp_q == '0) begin
                result  <= dst_q[1];
                finish  <= 1'b1;
                busy    <= 1'b0;
                state_q <= StDone;
              end else begin
                state_q <= exp_q[0] ? StMult : StSquare;
              end
`else
              bits_q  <= '0;
              state_q <= StMult;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        StMult: begin
          if (cnt_q == CW'(N - 1)) begin
            // Exponent bit selects r or the scratch register as destination.
            dst_q[exp_q[0]] <= acc_next;
            acc_q           <= '0;
            cnt_q           <= '0;
`ifdef MODEXP_EARLY_EXIT_EN
            if (exp_q[N-1:1] == '0) begin
              result  <= acc_next;
              finish  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StDone;
            end else begin
              state_q <= StSquare;
            end
`else
            state_q <= StSquare;
`endif
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end

        StSquare: begin
          if (cnt_q == CW'(N - 1)) begin
            b_q   <= acc_next;
            exp_q <= exp_q >> 1;
            acc_q <= '0;
            cnt_q <= '0;
`ifdef MODEXP_EARLY_EXIT_EN
            // SQUARE is only entered with exponent bits left above bit 0.
            state_q <= exp_q[1] ? StMult : StSquare;
`else
            if (bits_q == CW'(N - 1)) begin
              result  <= dst_q[1];
              finish  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StDone;
            end else begin
              bits_q  <= bits_q + CW'(1);
              state_q <= StMult;
            end
`endif
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine (WIDTH=8, 16-bit buses), with a
// plain square-and-multiply reference model.
module tb_mod_exp_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 2 * WIDTH;
  localparam int          CT_LAT = 1 + N + N * (2 * N);
  localparam int          LIMIT  = 4000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] base;
  logic [N-1:0] exponent;
  logic [N-1:0] modulus;
  logic [N-1:0] result;
  logic         busy;
  logic         finish;

  int pass_cnt = 0;
  int total_cnt = 0;

  mod_exp_engine #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .finish   (finish)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned ref_modexp(longint unsigned b, longint unsigned e,
                                                 longint unsigned m);
    longint unsigned r;
    if (m < 2) return 0;
    r = 1;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Launch one operation; lat counts clock edges after the accepting edge
  // until finish is seen. busy_ok is cleared if busy ever drops early or is
  // still high once finish rises.
  task automatic run_op(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] m,
                        output int lat, output logic [N-1:0] res, output bit busy_ok);
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (finish !== 1'b1 && lat < LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    res = result;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (result !== '0) $display("FAIL reset_result: got %0d want 0", result);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || finish !== 1'b0)
      $display("FAIL reset_flags: got busy=%b finish=%b want 0/0", busy, finish);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    logic [N-1:0] vb [7] = '{16'd4, 16'd65, 16'd2790, 16'd10, 16'd3, 16'd9, 16'd200};
    logic [N-1:0] ve [7] = '{16'd13, 16'd17, 16'd2753, 16'd1, 16'd0, 16'd5, 16'd3};
    logic [N-1:0] vm [7] = '{16'd497, 16'd3233, 16'd3233, 16'd7, 16'd7, 16'd1, 16'd0};
    logic [N-1:0] vr [7] = '{16'd445, 16'd2790, 16'd65, 16'd3, 16'd1, 16'd0, 16'd0};
    int lat;
    logic [N-1:0] res;
    bit busy_ok;
    for (int i = 0; i < 7; i++) begin
      run_op(vb[i], ve[i], vm[i], lat, res, busy_ok);
      total_cnt++;
      if (res !== vr[i])
        $display("FAIL vector%0d_result: got %0d want %0d", i, res, vr[i]);
      else pass_cnt++;
      if (vm[i] < 2) begin
        total_cnt++;
        if (lat != 0 || busy_ok != 1'b1)
          $display("FAIL vector%0d_trivial_latency: got %0d busy_ok=%0d want 0 1", i, lat,
                   busy_ok);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (busy_ok != 1'b1) $display("FAIL vector%0d_busy: got busy_ok=0 want 1", i);
        else pass_cnt++;
`ifndef MODEXP_EARLY_EXIT_EN
        total_cnt++;
        if (lat != CT_LAT) $display("FAIL vector%0d_latency: got %0d want %0d", i, lat, CT_LAT);
        else pass_cnt++;
`else
        total_cnt++;
        if (lat > CT_LAT) $display("FAIL vector%0d_latency: got %0d want <= %0d", i, lat, CT_LAT);
        else pass_cnt++;
`endif
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [N-1:0] res;
    logic [N-1:0] b, e, m;
    bit busy_ok;
    longint unsigned want;
    for (int i = 0; i < 10; i++) begin
      b = N'($urandom);
      e = (i % 3 == 0) ? N'($urandom_range(0, 20)) : N'($urandom);
      m = N'($urandom_range(2, 65535));
      want = ref_modexp(longint'(b), longint'(e), longint'(m));
      run_op(b, e, m, lat, res, busy_ok);
      total_cnt++;
      if (res !== N'(want) || busy_ok != 1'b1)
        $display("FAIL random%0d: %0d^%0d mod %0d got %0d busy_ok=%0d want %0d busy_ok=1",
                 i, b, e, m, res, busy_ok, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (finish !== 1'b1 && lat < LIMIT) begin
      if (lat == 40) begin
        @(negedge clk);
        base = 16'd5; exponent = 16'd7; modulus = 16'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      lat++;
    end
    total_cnt++;
    if (result !== 16'd445) $display("FAIL ignore_start_result: got %0d want 445", result);
    else pass_cnt++;
`ifndef MODEXP_EARLY_EXIT_EN
    total_cnt++;
    if (lat != CT_LAT) $display("FAIL ignore_start_latency: got %0d want %0d", lat, CT_LAT);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_start_together;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; base = 16'd4; exponent = 16'd13; modulus = 16'd497;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || finish !== 1'b0 || result !== '0)
      $display("FAIL reset_with_start: got busy=%b finish=%b result=%0d want 0 0 0",
               busy, finish, result);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset_mid_mult;
    int lat;
    logic [N-1:0] res;
    bit busy_ok;
    run_op(16'd4, 16'd13, 16'd497, lat, res, busy_ok);
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || finish !== 1'b0 || result !== '0)
      $display("FAIL reset_mid_mult: got busy=%b finish=%b result=%0d want 0 0 0",
               busy, finish, result);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    run_op(16'd65, 16'd17, 16'd3233, lat, res, busy_ok);
    total_cnt++;
    if (res !== 16'd2790 || busy_ok != 1'b1)
      $display("FAIL after_reset_result: got %0d busy_ok=%0d want 2790 1", res, busy_ok);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_reset_start_together();
    test_reset_mid_mult();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
